// File: rtl/barrel_shifter.sv
// barrel_shifter: registered log2-stage shift/rotate unit, configurable via BARREL_SHIFTER_PIPE_EN
// Ports: clock_i, reset_i (async, active-high); valid_i, mode_i (00 lsl, 01 lsr, 10 asr, 11 rol),
//        data_i, shift_i in; data_o, valid_o out after 1 cycle (2 cycles with BARREL_SHIFTER_PIPE_EN).
module barrel_shifter #(
    parameter int BW_DATA  = 32,
    parameter int BW_SHIFT = 5
) (
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                valid_i,
    input  logic [1:0]          mode_i,
    input  logic [BW_DATA-1:0]  data_i,
    input  logic [BW_SHIFT-1:0] shift_i,
    output logic [BW_DATA-1:0]  data_o,
    output logic                valid_o
);
    // stages below SPLIT run from the inputs, the rest from the (optional) mid register
    localparam int SPLIT = BW_SHIFT / 2;
    if (BW_DATA != 2 ** BW_SHIFT) begin : g_bad_width
        $error("barrel_shifter: BW_DATA must equal 2**BW_SHIFT");
    end
    logic [BW_DATA-1:0]      stg_in  [BW_SHIFT];
    logic [BW_DATA-1:0]      stg_out [BW_SHIFT];
    logic [BW_DATA-1:0]      lo_data;
    logic [BW_DATA-1:0]      hi_data;
    logic [BW_SHIFT-1:SPLIT] hi_shift;
    logic [1:0]              hi_mode;
    logic                    hi_valid;
    if (SPLIT == 0) begin : g_lo_in
        assign lo_data = data_i;
    end else begin : g_lo_stg
        assign lo_data = stg_out[SPLIT-1];
    end
`ifdef BARREL_SHIFTER_PIPE_EN
    logic [BW_DATA-1:0]      mid_data;
    logic [BW_SHIFT-1:SPLIT] mid_shift;
    logic [1:0]              mid_mode;
    logic                    mid_valid;
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mid_data  <= '0;
            mid_shift <= '0;
            mid_mode  <= '0;
            mid_valid <= 1'b0;
        end else begin
            mid_valid <= valid_i;
            if (valid_i) begin
                mid_data  <= lo_data;
                mid_shift <= shift_i[BW_SHIFT-1:SPLIT];
                mid_mode  <= mode_i;
            end
        end
    end
    assign hi_data  = mid_data;
    assign hi_shift = mid_shift;
    assign hi_mode  = mid_mode;
    assign hi_valid = mid_valid;
`else
    assign hi_data  = lo_data;
    assign hi_shift = shift_i[BW_SHIFT-1:SPLIT];
    assign hi_mode  = mode_i;
    assign hi_valid = valid_i;
`endif
    for (genvar k = 0; k < BW_SHIFT; k++) begin : g_stage
        localparam int A = 2 ** k;
        logic       sel;
        logic [1:0] md;
        if (k == SPLIT) begin : g_src_hi
            assign stg_in[k] = hi_data;
        end else if (k == 0) begin : g_src_in
            assign stg_in[k] = data_i;
        end else begin : g_src_prev
            assign stg_in[k] = stg_out[k-1];
        end
        if (k < SPLIT) begin : g_ctl_lo
            assign sel = shift_i[k];
            assign md  = mode_i;
        end else begin : g_ctl_hi
            assign sel = hi_shift[k];
            assign md  = hi_mode;
        end
        // arithmetic fill reuses the stage MSB: earlier stages already preserved the sign there
        assign stg_out[k] = !sel           ? stg_in[k] :
                            md == 2'b00    ? stg_in[k] << A :
                            md == 2'b01    ? stg_in[k] >> A :
                            md == 2'b10    ? (stg_in[k] >> A) | ({BW_DATA{stg_in[k][BW_DATA-1]}} << (BW_DATA - A)) :
                                             (stg_in[k] << A) | (stg_in[k] >> (BW_DATA - A));
    end
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= hi_valid;
            if (hi_valid) data_o <= stg_out[BW_SHIFT-1];
        end
    end
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: scoreboard bench for barrel_shifter (both latency builds)
module tb_barrel_shifter;
`ifdef BARREL_SHIFTER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        int          stamp;
        logic [31:0] exp;
    } item_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [1:0]  mode_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  shift_i = '0;
    logic [31:0] data_o;
    logic        valid_o;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] last = '0;
    item_t       q[$];
    barrel_shifter #(.BW_DATA(32), .BW_SHIFT(5)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .valid_i(valid_i),
        .mode_i(mode_i),
        .data_i(data_i),
        .shift_i(shift_i),
        .data_o(data_o),
        .valid_o(valid_o)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        sd = d;
        case (m)
            2'd0:    return d << s;
            2'd1:    return d >> s;
            2'd2:    return 32'(sd >>> s);
            default: return (d << s) | (d >> (6'd32 - {1'b0, s}));
        endcase
    endfunction
    task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        @(posedge clk);
        #1;
        valid_i = 1'b1;
        mode_i  = m;
        data_i  = d;
        shift_i = s;
        q.push_back('{stamp: cyc, exp: model(m, d, s)});
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            data_i  = $urandom;
        end
    endtask
    always @(negedge clk) begin
        if (rst) last = '0;
        else if (valid_o) begin
            if (q.size() == 0) check("unexpected_valid", 32'(valid_o), 32'd0);
            else begin
                item_t e;
                e = q.pop_front();
                check("data", data_o, e.exp);
                check("latency", 32'(cyc), 32'(e.stamp + LAT));
            end
            last = data_o;
        end else check("hold", data_o, last);
    end
    initial begin
        #2;
        check("rst_data", data_o, 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        // spot checks from the plan
        send(2'b00, 32'h0000_0001, 5'd4);
        send(2'b00, 32'h0000_0010, 5'd31);
        send(2'b01, 32'h8000_0000, 5'd31);
        send(2'b10, 32'h8000_0000, 5'd4);
        send(2'b10, 32'h7FFF_FFFF, 5'd31);
        send(2'b11, 32'h8000_0001, 5'd1);
        send(2'b11, 32'h1234_5678, 5'd0);
        idle(1);
        send(2'b11, 32'hA5A5_0F0F, 5'd31);
        send(2'b10, 32'hC000_0003, 5'd0);
        send(2'b00, 32'hFFFF_FFFF, 5'd31);
        idle(3);
        // one-hot left sweep
        for (int i = 0; i < 12; i++) begin
            send(2'b00, 32'd1 << $urandom_range(0, 31), 5'($urandom_range(0, 31)));
            if (i % 4 == 3) idle(1);
        end
        // random mix across all modes with occasional bubbles
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        // mid-stream asynchronous reset while results are still flowing
        send(2'b00, 32'h0000_00FF, 5'd8);
        send(2'b01, 32'hFF00_0000, 5'd8);
        send(2'b11, 32'hF000_000F, 5'd4);
        @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_data", data_o, 32'd0);
        check("async_rst_valid", 32'(valid_o), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);
        send(2'b10, 32'h8000_0000, 5'd31);
        send(2'b00, 32'h0000_0001, 5'd31);
        idle(1);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Registered, parameterised barrel shifter: shifts or rotates a BW_DATA-bit word by a BW_SHIFT-bit amount in a single pass.
- Built as log2 mux stages (one stage per shift-amount bit), followed by an output register.
- Used as a datapath utility, e.g. for one-hot index and mask generation and alignment in the cache controller.

Parameters:
- BW_DATA, 32, data word width; must equal 2**BW_SHIFT.
- BW_SHIFT, 5, shift-amount width; supports shifts 0..BW_DATA-1.

Ports:
- clock_i  input  1  system clock, rising-edge active.
- reset_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  qualifies data_i/shift_i/mode_i this cycle.
- mode_i  input  2  operation: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
- data_i  input  BW_DATA  operand.
- shift_i  input  BW_SHIFT  shift amount, unsigned.
- data_o  output  BW_DATA  shifted result.
- valid_o  output  1  data_o holds a valid result.

Behaviour:
- Reset: while reset_i is high, data_o=0 and valid_o=0 immediately (asynchronous clear). Outputs are held while reset is asserted. Normal operation resumes on the first rising edge after deassertion.
- Latency: 1 cycle. Inputs sampled on the rising edge with valid_i=1 appear on data_o/valid_o after that edge. Throughput is one result per cycle; no backpressure.
- valid_i=0 at an edge:
  - valid_o goes to 0.
  - data_o holds its previous value (the register enable is valid_i).
- Stage k (k=0..BW_SHIFT-1) shifts by 2**k when shift_i[k]=1, otherwise passes through. The stages are combinational between the input and the output register.
- Fill bits:
  - Logical left: zeros into the LSBs.
  - Logical right: zeros into the MSBs.
  - Arithmetic right: copies of data_i[BW_DATA-1] into the MSBs.
  - Rotate left: bits shifted out of the MSB re-enter at the LSB.
- shift_i=0: data_o equals data_i for all modes.
- Maximum shift (BW_DATA-1):
  - Left: only data_i[0] survives, at the MSB.
  - Logical right: only data_i[MSB] survives, at the LSB.
  - Arithmetic right: all bits equal the sign bit.
  - Rotate left: equivalent to rotate right by 1.
- No undefined outputs: X/Z never propagated from internal logic; all mux selects are fully decoded.
- Elaboration check: generate a compile-time error if BW_DATA != 2**BW_SHIFT.

Optional Feature:
- Macro: BARREL_SHIFTER_PIPE_EN.
- Defined:
  - An extra pipeline register is inserted after stage floor(BW_SHIFT/2)-1, carrying the partial result, the remaining shift bits, mode and valid.
  - Latency becomes 2 cycles; throughput stays 1 per cycle.
  - The mid register is also asynchronously cleared by reset_i, so no stale valid emerges after reset.
- Undefined: single output register, latency 1.
- Functional results are identical in both builds apart from latency.

Test Plan:
- Reset: assert reset_i mid-stream while valid_o=1 -> data_o=0 and valid_o=0 immediately, before any clock edge. After release, first valid input is processed normally.
- One-hot left sweep: mode 00, data_i=1<<r and shift_i=s for random r,s over 10+ iterations -> data_o=(1<<(r+s)) truncated to 32 bits, one cycle later. Spot checks:
  - data 0x00000001, shift 4 -> 0x00000010.
  - data 0x00000010, shift 31 -> 0x00000000.
- Right shifts, data 0x80000000:
  - Mode 01, shift 31 -> 0x00000001.
  - Mode 10, shift 4 -> 0xF8000000.
  - Mode 10 with data 0x7FFFFFFF, shift 31 -> 0x00000000.
- Rotate, mode 11:
  - data 0x80000001, shift 1 -> 0x00000003.
  - data 0x12345678, shift 0 -> 0x12345678.
- Valid gating: back-to-back valid inputs produce back-to-back results in order. A cycle with valid_i=0 -> valid_o=0 next cycle with data_o unchanged.
- With BARREL_SHIFTER_PIPE_EN defined: rerun all scenarios -> same values with valid_o/data_o arriving 2 cycles after input.
